// File: rtl/wave_period_meter.sv
// Square-wave period meter: synchronizes a toggling input, detects rising edges and
// reports period and high time in clock cycles, with lock, sticky timeout and edge count.
module wave_period_meter #(
    parameter int WIDTH   = 16,
    parameter bit SYNC_EN = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             sig_in,
    input  logic             clear,
    output logic [WIDTH-1:0] period_out,
    output logic [WIDTH-1:0] high_out,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout,
    output logic [WIDTH-1:0] edge_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_hcnt, w_hcnt_nxt;
    logic             r_high_run, w_high_run_nxt;
    logic [WIDTH-1:0] r_period, w_period_nxt;
    logic [WIDTH-1:0] r_high, w_high_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_locked, w_locked_nxt;
    logic             r_timeout, w_timeout_nxt;
    logic [WIDTH-1:0] r_edges, w_edges_nxt;
    logic             r_s_d;
    logic             w_s, w_rise, w_fall, w_start;

    generate
        if (SYNC_EN) begin : g_sync
            logic r_sync1, r_sync2;
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                end else begin
                    r_sync1 <= sig_in;
                    r_sync2 <= r_sync1;
                end
            end
            assign w_s = r_sync2;
        end else begin : g_direct
            assign w_s = sig_in;
        end
    endgenerate

    assign w_rise = w_s & ~r_s_d;
    assign w_fall = ~w_s & r_s_d;

    always_comb begin
        // NOTE: every target gets a default before any branch, so no path leaves a latch.
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_hcnt_nxt     = r_hcnt;
        w_high_run_nxt = r_high_run;
        w_period_nxt   = r_period;
        w_high_nxt     = r_high;
        w_valid_nxt    = 1'b0;
        w_locked_nxt   = r_locked;
        w_timeout_nxt  = r_timeout;
        w_edges_nxt    = r_edges;
        w_start        = 1'b0;

        if (clear) begin
            // Clear beats a simultaneous rise: that edge is simply dropped.
            w_state_nxt    = ST_IDLE;
            w_cnt_nxt      = '0;
            w_hcnt_nxt     = '0;
            w_high_run_nxt = 1'b0;
            w_period_nxt   = '0;
            w_high_nxt     = '0;
            w_locked_nxt   = 1'b0;
            w_timeout_nxt  = 1'b0;
            w_edges_nxt    = '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_TIMEOUT: begin
                    if (w_rise) w_start = 1'b1;
                end
                ST_MEASURE: begin
                    if (w_rise) begin
                        w_period_nxt = r_cnt;
                        w_high_nxt   = r_hcnt;
                        w_valid_nxt  = 1'b1;
                        w_locked_nxt = 1'b1;
                        w_start      = 1'b1;
                    end else if (r_cnt == CNT_MAX) begin
                        w_state_nxt   = ST_TIMEOUT;
                        w_timeout_nxt = 1'b1;
                        w_locked_nxt  = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                        if (r_high_run && w_s) w_hcnt_nxt = r_hcnt + CNT_ONE;
                        if (w_fall) w_high_run_nxt = 1'b0;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase

            if (w_start) begin
                w_state_nxt    = ST_MEASURE;
                w_cnt_nxt      = CNT_ONE;
                w_hcnt_nxt     = CNT_ONE;
                w_high_run_nxt = 1'b1;
                w_edges_nxt    = r_edges + CNT_ONE;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_hcnt     <= '0;
            r_high_run <= 1'b0;
            r_period   <= '0;
            r_high     <= '0;
            r_valid    <= 1'b0;
            r_locked   <= 1'b0;
            r_timeout  <= 1'b0;
            r_edges    <= '0;
            r_s_d      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_hcnt     <= w_hcnt_nxt;
            r_high_run <= w_high_run_nxt;
            r_period   <= w_period_nxt;
            r_high     <= w_high_nxt;
            r_valid    <= w_valid_nxt;
            r_locked   <= w_locked_nxt;
            r_timeout  <= w_timeout_nxt;
            r_edges    <= w_edges_nxt;
            r_s_d      <= w_s;
        end
    end

    assign period_out   = r_period;
    assign high_out     = r_high;
    assign period_valid = r_valid;
    assign locked       = r_locked;
    assign timeout      = r_timeout;
    assign edge_count   = r_edges;

endmodule

// File: tb/tb_wave_period_meter.sv
// Bench for wave_period_meter: three instances (direct, synchronized, 8-bit) checked
// every cycle against a timestamp-based reference model plus directed waveform tables.
module tb_wave_period_meter;

    logic clock, reset_n, sig_in, clear;

    logic [15:0] p0, h0, e0, p1, h1, e1;
    logic [7:0]  p2, h2, e2;
    logic        v0, l0, t0, v1, l1, t1, v2, l2, t2;

    wave_period_meter #(.WIDTH(16), .SYNC_EN(1'b0)) d0 (
        .clock(clock), .reset_n(reset_n), .sig_in(sig_in), .clear(clear),
        .period_out(p0), .high_out(h0), .period_valid(v0), .locked(l0),
        .timeout(t0), .edge_count(e0));

    wave_period_meter #(.WIDTH(16), .SYNC_EN(1'b1)) d1 (
        .clock(clock), .reset_n(reset_n), .sig_in(sig_in), .clear(clear),
        .period_out(p1), .high_out(h1), .period_valid(v1), .locked(l1),
        .timeout(t1), .edge_count(e1));

    wave_period_meter #(.WIDTH(8), .SYNC_EN(1'b0)) d2 (
        .clock(clock), .reset_n(reset_n), .sig_in(sig_in), .clear(clear),
        .period_out(p2), .high_out(h2), .period_valid(v2), .locked(l2),
        .timeout(t2), .edge_count(e2));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: each instance remembers the cycle of its reference rise and the
    // first low cycle after it; period and high time are plain timestamp differences.
    int cyc = 0;
    int m_max[3] = '{65535, 65535, 255};
    bit m_has_ref[3], m_prev[3], m_valid[3], m_locked[3], m_to[3];
    int m_ref[3], m_flow[3], m_per[3], m_high[3], m_edges[3];
    bit sh1, sh2;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_has_ref[i] = 0; m_prev[i] = 0; m_valid[i] = 0; m_locked[i] = 0; m_to[i] = 0;
            m_ref[i] = 0; m_flow[i] = -1; m_per[i] = 0; m_high[i] = 0; m_edges[i] = 0;
        end
        sh1 = 0; sh2 = 0;
    endtask

    task automatic model_one(input int i, input bit s, input bit clr);
        bit rise;
        rise = s && !m_prev[i];
        m_valid[i] = 0;
        if (clr) begin
            m_has_ref[i] = 0; m_per[i] = 0; m_high[i] = 0;
            m_locked[i] = 0; m_to[i] = 0; m_edges[i] = 0;
        end else if (rise) begin
            if (m_has_ref[i]) begin
                m_per[i]    = cyc - m_ref[i];
                m_high[i]   = (m_flow[i] >= 0) ? m_flow[i] - m_ref[i] : cyc - m_ref[i];
                m_valid[i]  = 1;
                m_locked[i] = 1;
            end
            m_has_ref[i] = 1;
            m_ref[i]     = cyc;
            m_flow[i]    = -1;
            m_edges[i]   = (m_edges[i] + 1) & m_max[i];
        end else if (m_has_ref[i]) begin
            if (cyc - m_ref[i] == m_max[i]) begin
                m_has_ref[i] = 0; m_to[i] = 1; m_locked[i] = 0;
            end else if (!s && m_flow[i] < 0) begin
                m_flow[i] = cyc;
            end
        end
        m_prev[i] = s;
    endtask

    task automatic model_step();
        bit s_sync;
        s_sync = sh2;
        sh2 = sh1;
        sh1 = sig_in;
        model_one(0, sig_in, clear);
        model_one(1, s_sync, clear);
        model_one(2, sig_in, clear);
        cyc++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    function automatic longint pk(input int per, input int high, input int edges,
                                  input bit v, input bit l, input bit t);
        return (longint'(per) << 35) | (longint'(high) << 19) | (longint'(edges) << 3)
             | longint'({v, l, t});
    endfunction

    initial begin
        forever begin
            @(negedge clock);
            if (chk_en) begin
                check("model_d0", pk(p0, h0, e0, v0, l0, t0),
                      pk(m_per[0], m_high[0], m_edges[0], m_valid[0], m_locked[0], m_to[0]));
                check("model_d1", pk(p1, h1, e1, v1, l1, t1),
                      pk(m_per[1], m_high[1], m_edges[1], m_valid[1], m_locked[1], m_to[1]));
                check("model_d2", pk(p2, h2, e2, v2, l2, t2),
                      pk(m_per[2], m_high[2], m_edges[2], m_valid[2], m_locked[2], m_to[2]));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic hold(input bit v, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            sig_in = v;
        end
    endtask

    // Drives n periods of hi cycles high then lo cycles low; counts d0 period_valid pulses.
    task automatic drive_wave(input int hi, input int lo, input int n, output int nv);
        nv = 0;
        for (int p = 0; p < n; p++) begin
            for (int k = 0; k < hi + lo; k++) begin
                @(negedge clock);
                if (v0) nv++;
                sig_in = (k < hi);
            end
        end
    endtask

    task automatic pulse_clear();
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    typedef struct {
        int hi;
        int lo;
        int per;
        int high;
    } vec_t;

    vec_t vecs[6];
    int   nv;
    int   lat0, lat1;
    bit   rv;

    initial begin
        vecs[0] = '{1, 1, 2, 1};
        vecs[1] = '{2, 2, 4, 2};
        vecs[2] = '{3, 7, 10, 3};
        vecs[3] = '{5, 1, 6, 5};
        vecs[4] = '{1, 4, 5, 1};
        vecs[5] = '{4, 4, 8, 4};

        reset_n = 1'b0;
        sig_in  = 1'b0;
        clear   = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_period", p0, 0);
        check("rst_edges", e1, 0);
        check("rst_flags", {v0, l0, t0, v2, l2, t2}, 0);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // Steady waveforms: period/high as tabulated on all three instances.
        for (int v = 0; v < 6; v++) begin
            pulse_clear();
            hold(0, 3);
            drive_wave(vecs[v].hi, vecs[v].lo, 4, nv);
            hold(0, 3);
            check($sformatf("tbl%0d_nvalid", v), nv, 3);
            check($sformatf("tbl%0d_p0", v), p0, vecs[v].per);
            check($sformatf("tbl%0d_h0", v), h0, vecs[v].high);
            check($sformatf("tbl%0d_p1", v), p1, vecs[v].per);
            check($sformatf("tbl%0d_h1", v), h1, vecs[v].high);
            check($sformatf("tbl%0d_p2", v), p2, vecs[v].per);
            check($sformatf("tbl%0d_lock", v), {l0, l1, l2}, 3'b111);
        end

        // Synchronizer latency: first period_valid of d1 exactly 2 cycles after d0.
        pulse_clear();
        hold(0, 4);
        lat0 = -1;
        lat1 = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (v0 && lat0 < 0) lat0 = i;
            if (v1 && lat1 < 0) lat1 = i;
            sig_in = ((i / 2) % 2 == 0);
        end
        check("sync_latency", lat1 - lat0, 2);
        check("sync_lat_seen", lat0 >= 0, 1);

        // Fastest input plus edge_count wrap on the 8-bit instance.
        pulse_clear();
        hold(0, 3);
        drive_wave(1, 1, 260, nv);
        hold(0, 3);
        check("fast_nvalid", nv, 259);
        check("fast_p0", p0, 2);
        check("fast_h0", h0, 1);
        check("edges_d0", e0, 260);
        check("edges_wrap_d2", e2, 4);

        // Timeout on the 8-bit instance; reported values hold, timeout is sticky.
        pulse_clear();
        hold(0, 3);
        drive_wave(2, 2, 4, nv);
        hold(0, 300);
        check("to_d2_flags", {t2, l2}, 2'b10);
        check("to_d2_hold", {p2, h2}, {8'd4, 8'd2});
        check("to_d0_flags", {t0, l0}, 2'b01);
        drive_wave(3, 3, 2, nv);
        hold(0, 3);
        check("to_after_per", p2, 6);
        check("to_after_high", h2, 3);
        check("to_after_flags", {t2, l2}, 2'b11);
        check("to_after_edges", e2, 6);

        // Clear coinciding with a rise: edge dropped, outputs zeroed, timeout cleared.
        hold(0, 3);
        @(negedge clock);
        sig_in = 1'b1;
        clear  = 1'b1;
        @(negedge clock);
        check("clr_rise_valid", v0, 0);
        check("clr_rise_out", {p0, h0, e0}, 0);
        check("clr_rise_flags", {l0, t2, l2}, 0);
        sig_in = 1'b0;
        clear  = 1'b0;
        hold(0, 3);
        drive_wave(2, 3, 3, nv);
        hold(0, 3);
        check("clr_after_nvalid", nv, 2);
        check("clr_after_ph", {p0, h0}, {16'd5, 16'd2});
        check("clr_after_edges", e0, 3);

        // Asynchronous reset between clock edges in the middle of a period.
        drive_wave(2, 2, 2, nv);
        hold(1, 1);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("arst_out", {p0, h0, e0, p2}, 0);
        check("arst_flags", {v0, l0, t0, l1}, 0);
        #1 reset_n = 1'b1;
        hold(0, 2);
        drive_wave(2, 2, 1, nv);
        check("arst_first_rise", {nv[0], l0}, 0);
        drive_wave(2, 2, 1, nv);
        check("arst_second_rise", nv, 1);
        check("arst_lock", l0, 1);

        // Random run lengths with occasional clear, checked cycle-by-cycle against the model.
        pulse_clear();
        rv = 1'b0;
        for (int r = 0; r < 400; r++) begin
            if ($urandom_range(0, 60) == 0) pulse_clear();
            rv = ~rv;
            hold(rv, $urandom_range(1, 6));
        end
        hold(0, 5);

        @(negedge clock);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
